// File: rtl/ltpi_gpio_param.sv
`default_nettype none
// ============================================================================
// Module   : ltpi_gpio_param
// Brief    : LTPI normal-latency GPIO channel. TX slices a wide GPIO vector
//            into indexed per-frame chunks for the framer; RX rebuilds the
//            wide GPIO output vector from indexed chunks from the deframer.
// Revision : 1.0 - initial release
// ============================================================================
module ltpi_gpio_param #(
  parameter int                  NUM_GPIO       = 64,
  parameter int                  BITS_PER_FRAME = 16,
  parameter logic [NUM_GPIO-1:0] DEFAULT_OUT    = '0,
  localparam int NUM_FRAMES = (BITS_PER_FRAME > 0) ? (NUM_GPIO / BITS_PER_FRAME) : 1,
  localparam int IDX_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      link_aligned,
  input  logic [NUM_GPIO-1:0]       gpio_in,
  input  logic                      tx_frame_req,
  output logic                      tx_valid,
  output logic [IDX_W-1:0]          tx_index,
  output logic [BITS_PER_FRAME-1:0] tx_data,
  input  logic                      rx_valid,
  input  logic [IDX_W-1:0]          rx_index,
  input  logic [BITS_PER_FRAME-1:0] rx_data,
  output logic [NUM_GPIO-1:0]       gpio_out,
  output logic                      rx_index_err
);

  // Reject configurations where the vector does not split into whole frames.
  if (BITS_PER_FRAME <= 0 || NUM_GPIO <= 0 || (NUM_GPIO % BITS_PER_FRAME) != 0) begin : g_cfg_check
    $error("ltpi_gpio_param: NUM_GPIO must be a non-zero multiple of BITS_PER_FRAME");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);
  localparam logic [IDX_W:0]   FRAMES_W = (IDX_W+1)'(NUM_FRAMES);

  logic [IDX_W-1:0]          tx_cnt;
  logic [BITS_PER_FRAME-1:0] tx_slice;
  logic                      rx_in_range;

  // Select the chunk of gpio_in addressed by the rolling TX counter.
  always_comb begin
    tx_slice = '0;
    for (int f = 0; f < NUM_FRAMES; f++) begin
      if (tx_cnt == IDX_W'(f)) begin
        tx_slice = gpio_in[f*BITS_PER_FRAME +: BITS_PER_FRAME];
      end
    end
  end

  // Indices past the last frame exist only for non-power-of-two frame counts.
  always_comb begin
    rx_in_range = ({1'b0, rx_index} < FRAMES_W);
  end

  // TX: register one indexed chunk per framer request; counter rolls over the frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_index <= '0;
      tx_data  <= '0;
      tx_cnt   <= '0;
    end else if (!link_aligned) begin
      // Restart from index 0 so the far end resynchronises on realignment.
      tx_valid <= 1'b0;
      tx_cnt   <= '0;
    end else if (tx_frame_req) begin
      tx_valid <= 1'b1;
      tx_index <= tx_cnt;
      tx_data  <= tx_slice;
      tx_cnt   <= (tx_cnt == LAST_IDX) ? '0 : tx_cnt + IDX_W'(1);
    end else begin
      tx_valid <= 1'b0;
    end
  end

  // RX: write received chunk into its slice; fall back to defaults when the link drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out     <= DEFAULT_OUT;
      rx_index_err <= 1'b0;
    end else if (!link_aligned) begin
      gpio_out     <= DEFAULT_OUT;
      rx_index_err <= 1'b0;
    end else begin
      rx_index_err <= rx_valid && !rx_in_range;
      if (rx_valid && rx_in_range) begin
        for (int f = 0; f < NUM_FRAMES; f++) begin
          if (rx_index == IDX_W'(f)) begin
            gpio_out[f*BITS_PER_FRAME +: BITS_PER_FRAME] <= rx_data;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ltpi_gpio_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltpi_gpio_param
// Brief    : Self-checking bench for ltpi_gpio_param. Two instances share all
//            stimulus: a 64-bit/4-frame channel with a non-zero default and a
//            48-bit/3-frame channel that exercises out-of-range RX indices.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ltpi_gpio_param;

  localparam logic [63:0] DFLT0 = 64'hA5A5_A5A5_A5A5_A5A5;

  logic        clk;
  logic        reset;
  logic        link_aligned;
  logic [63:0] gpio_in;
  logic        tx_frame_req;
  logic        rx_valid;
  logic [1:0]  rx_index;
  logic [15:0] rx_data;

  logic        tx_valid0, tx_valid1;
  logic [1:0]  tx_index0, tx_index1;
  logic [15:0] tx_data0, tx_data1;
  logic [63:0] gpio_out0;
  logic [47:0] gpio_out1;
  logic        rx_index_err0, rx_index_err1;

  int checks;
  int failures;

  // Reference model state, one entry per instance.
  int          m_nfr  [2];
  logic [63:0] m_dflt [2];
  int          m_cnt  [2];
  logic        m_txv  [2];
  int          m_txi  [2];
  logic [15:0] m_txd  [2];
  logic [63:0] m_out  [2];
  logic        m_err  [2];

  ltpi_gpio_param #(
    .NUM_GPIO(64), .BITS_PER_FRAME(16), .DEFAULT_OUT(DFLT0)
  ) dut0 (
    .clk(clk), .reset(reset), .link_aligned(link_aligned), .gpio_in(gpio_in),
    .tx_frame_req(tx_frame_req), .tx_valid(tx_valid0), .tx_index(tx_index0),
    .tx_data(tx_data0), .rx_valid(rx_valid), .rx_index(rx_index),
    .rx_data(rx_data), .gpio_out(gpio_out0), .rx_index_err(rx_index_err0)
  );

  ltpi_gpio_param #(
    .NUM_GPIO(48), .BITS_PER_FRAME(16), .DEFAULT_OUT(48'h0)
  ) dut1 (
    .clk(clk), .reset(reset), .link_aligned(link_aligned), .gpio_in(gpio_in[47:0]),
    .tx_frame_req(tx_frame_req), .tx_valid(tx_valid1), .tx_index(tx_index1),
    .tx_data(tx_data1), .rx_valid(rx_valid), .rx_index(rx_index),
    .rx_data(rx_data), .gpio_out(gpio_out1), .rx_index_err(rx_index_err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      m_txv[d] = 1'b0;
      m_txi[d] = 0;
      m_txd[d] = '0;
      m_out[d] = m_dflt[d];
      m_err[d] = 1'b0;
    end
  endtask

  // Next-state of each channel from the inputs presented this cycle.
  task automatic model_clock();
    logic [63:0] vec;
    for (int d = 0; d < 2; d++) begin
      vec = (d == 0) ? gpio_in : {16'h0, gpio_in[47:0]};
      if (!link_aligned) begin
        m_cnt[d] = 0;
        m_txv[d] = 1'b0;
        m_out[d] = m_dflt[d];
        m_err[d] = 1'b0;
      end else begin
        if (tx_frame_req) begin
          m_txv[d] = 1'b1;
          m_txi[d] = m_cnt[d];
          m_txd[d] = 16'((vec >> (16 * m_cnt[d])) & 64'hFFFF);
          m_cnt[d] = (m_cnt[d] + 1) % m_nfr[d];
        end else begin
          m_txv[d] = 1'b0;
        end
        m_err[d] = 1'b0;
        if (rx_valid) begin
          if (int'(rx_index) < m_nfr[d]) m_out[d][16*rx_index +: 16] = rx_data;
          else                           m_err[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all(input string where);
    check_val({where, ".tx_valid0"}, 64'(tx_valid0), 64'(m_txv[0]));
    check_val({where, ".tx_index0"}, 64'(tx_index0), 64'(m_txi[0]));
    check_val({where, ".tx_data0"},  64'(tx_data0),  64'(m_txd[0]));
    check_val({where, ".gpio_out0"}, gpio_out0,      m_out[0]);
    check_val({where, ".rx_err0"},   64'(rx_index_err0), 64'(m_err[0]));
    check_val({where, ".tx_valid1"}, 64'(tx_valid1), 64'(m_txv[1]));
    check_val({where, ".tx_index1"}, 64'(tx_index1), 64'(m_txi[1]));
    check_val({where, ".tx_data1"},  64'(tx_data1),  64'(m_txd[1]));
    check_val({where, ".gpio_out1"}, {16'h0, gpio_out1}, m_out[1]);
    check_val({where, ".rx_err1"},   64'(rx_index_err1), 64'(m_err[1]));
  endtask

  // One clock: model advances on the presented inputs, DUT sampled 1ns after the edge.
  task automatic step(input string where);
    model_clock();
    @(posedge clk);
    #1;
    compare_all(where);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_nfr[0] = 4;  m_dflt[0] = DFLT0;
    m_nfr[1] = 3;  m_dflt[1] = 64'h0;
    model_reset();

    reset = 1'b1;
    link_aligned = 1'b0;
    gpio_in = '0;
    tx_frame_req = 1'b0;
    rx_valid = 1'b0;
    rx_index = '0;
    rx_data = '0;

    // Reset state while reset is held.
    #12;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b0;
    step("post_reset");

    // Back-to-back TX requests; 48-bit channel wraps after index 2.
    link_aligned = 1'b1;
    gpio_in = 64'h4444_3333_2222_1111;
    tx_frame_req = 1'b1;
    for (int i = 0; i < 5; i++) step("tx_burst");
    tx_frame_req = 1'b0;
    step("tx_idle");

    // RX writes to slices 2 then 0.
    rx_valid = 1'b1; rx_index = 2'd2; rx_data = 16'hBEEF;
    step("rx_w2");
    rx_index = 2'd0; rx_data = 16'h1234;
    step("rx_w0");
    check_val("rx_lit0", gpio_out0, 64'hA5A5_BEEF_A5A5_1234);
    check_val("rx_lit1", {16'h0, gpio_out1}, 64'h0000_BEEF_0000_1234);
    rx_valid = 1'b0;
    step("rx_hold");

    // One-cycle link drop restores defaults and restarts the TX index.
    link_aligned = 1'b0;
    step("link_drop");
    link_aligned = 1'b1;
    tx_frame_req = 1'b1;
    step("realign_tx");
    check_val("realign_idx0", 64'(tx_index0), 64'd0);
    tx_frame_req = 1'b0;

    // Index 3: valid slice on the 4-frame channel, out of range on the 3-frame one.
    rx_valid = 1'b1; rx_index = 2'd3; rx_data = 16'hC0DE;
    step("rx_idx3");
    check_val("idx3_err1", 64'(rx_index_err1), 64'd1);
    rx_valid = 1'b0;
    step("rx_idx3_after");
    check_val("idx3_err1_clr", 64'(rx_index_err1), 64'd0);

    // rx_valid while not aligned is ignored without error.
    link_aligned = 1'b0; rx_valid = 1'b1; rx_index = 2'd3;
    step("rx_unaligned");
    rx_valid = 1'b0; link_aligned = 1'b1;

    // Asynchronous reset in the middle of a TX burst.
    tx_frame_req = 1'b1;
    step("burst_a");
    step("burst_b");
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clk);
    #1;
    compare_all("rst_held");
    @(negedge clk);
    reset = 1'b0;
    step("after_rst");
    check_val("after_rst_idx", 64'(tx_index0), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      link_aligned = ($urandom_range(0, 9) != 0);
      gpio_in      = {$urandom, $urandom};
      tx_frame_req = 1'($urandom_range(0, 1));
      rx_valid     = 1'($urandom_range(0, 1));
      rx_index     = 2'($urandom_range(0, 3));
      rx_data      = 16'($urandom);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ltpi_gpio_param.md
Name: ltpi_gpio_param

Overview:
- Parameterizable LTPI normal-latency GPIO channel.
- TX half slices a wide parallel GPIO input vector into fixed-width per-frame chunks, each tagged with a rolling frame index, for the LTPI framer.
- RX half takes received (index, chunk) pairs from the deframer and rebuilds the wide parallel GPIO output vector.
- Sits between the LTPI link layer and the board-level GPIO pins on both SCM and HPM sides.

Parameters:
- NUM_GPIO, 64, total GPIO bits carried; must be a non-zero multiple of BITS_PER_FRAME (elaboration-time $error otherwise).
- BITS_PER_FRAME, 16, GPIO bits carried per LTPI frame.
- DEFAULT_OUT, all zeros (NUM_GPIO bits), value driven on gpio_out during reset and while the link is not aligned.
- Derived: NUM_FRAMES = NUM_GPIO/BITS_PER_FRAME; IDX_W = max(1, $clog2(NUM_FRAMES)).

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- link_aligned  input  1  LTPI link operational; gates both halves.
- gpio_in  input  NUM_GPIO  parallel GPIO to transmit.
- tx_frame_req  input  1  one-cycle request from framer for the next chunk.
- tx_valid  output  1  chunk valid (one-cycle pulse).
- tx_index  output  IDX_W  index of the chunk on tx_data.
- tx_data  output  BITS_PER_FRAME  chunk = gpio_in[tx_index*BITS_PER_FRAME +: BITS_PER_FRAME].
- rx_valid  input  1  received chunk valid.
- rx_index  input  IDX_W  index of received chunk.
- rx_data  input  BITS_PER_FRAME  received chunk bits.
- gpio_out  output  NUM_GPIO  reconstructed GPIO vector.
- rx_index_err  output  1  one-cycle pulse on an out-of-range rx_index.

Behaviour:
- Reset (async assert, sync release):
  - tx_valid=0, tx_index=0, tx_data=0.
  - Internal tx counter = 0.
  - gpio_out=DEFAULT_OUT, rx_index_err=0.
- TX:
  - If tx_frame_req=1 and link_aligned=1, the next clock edge registers tx_valid=1, tx_index=counter, tx_data=slice of gpio_in sampled in the request cycle. Latency is 1 cycle.
  - Counter then increments, wrapping NUM_FRAMES-1 -> 0.
  - Otherwise tx_valid=0 next cycle; tx_index and tx_data hold their last values.
  - link_aligned=0 clears the counter to 0 (synchronously) and forces tx_valid=0. The first chunk after alignment is index 0.
  - Back-to-back requests (every cycle) are supported with no bubbles.
- RX:
  - If rx_valid=1, link_aligned=1 and rx_index<NUM_FRAMES, the next edge writes gpio_out[rx_index*BITS_PER_FRAME +: BITS_PER_FRAME]=rx_data. Latency is 1 cycle.
  - All other slices hold their values.
  - If rx_valid=1, link_aligned=1 and rx_index>=NUM_FRAMES (only possible when NUM_FRAMES is not a power of two): gpio_out is unchanged and rx_index_err=1 for exactly one cycle. Otherwise rx_index_err=0.
  - rx_valid while link_aligned=0 is ignored and no error is flagged.
  - A cycle with link_aligned=0 loads gpio_out=DEFAULT_OUT on the next edge. The value is held at DEFAULT_OUT until new chunks arrive after realignment; slices not yet received stay at DEFAULT_OUT.
- TX and RX are independent; simultaneous tx_frame_req and rx_valid are both serviced in the same cycle.
- NUM_FRAMES=1 is legal: the index is always 0 and the counter stays 0.
- Reset asserted mid-operation immediately returns all outputs to their reset values, regardless of clock.

Test Plan:
- Reset with DEFAULT_OUT=64'hA5A5_A5A5_A5A5_A5A5 -> gpio_out equals the default and tx_valid=0 while reset is high and after release.
- link_aligned=1, gpio_in=64'h4444_3333_2222_1111, five consecutive tx_frame_req pulses -> (index,data) = (0,1111),(1,2222),(2,3333),(3,4444),(0,1111), each one cycle after its request.
- rx_valid with (2,16'hBEEF) then (0,16'h1234) from default 0 -> gpio_out=64'h0000_BEEF_0000_1234 one cycle after the last write.
- Drop link_aligned for one cycle after the RX writes above -> gpio_out returns to DEFAULT_OUT; the next tx_frame_req after realignment yields tx_index=0.
- NUM_GPIO=48, BITS_PER_FRAME=16, rx_index=3 with rx_valid -> gpio_out unchanged and rx_index_err pulses high for one cycle; TX index sequence wraps 0,1,2,0.
- Assert reset asynchronously (between clock edges) in the middle of a TX burst -> tx_valid drops immediately and the first request after release yields index 0.
